rom_bus_sequencer: RTL

ROM_BUS_SEQUENCER -- requirements
Module: rom_bus_sequencer

---
 rtl/rom_bus_sequencer_if.sv | 37 +++
 rtl/rom_bus_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/rom_bus_sequencer_if.sv
// Z80/CPC-side strobes and buses plus the ROM-store fetch handshake, grouped for the sequencer.
// The sequencer uses the slave modport; a bus model or bench drives the master side.
interface rom_bus_sequencer_if;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_d;
   logic        mreq_b;
   logic        iorq_b;
   logic        rd_b;
   logic        wr_b;
   logic        m1_b;
   logic        romen_b;
   logic [15:0] slot_mask;
   logic        low_rom_en;

   logic        mem_req;
   logic [18:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_data;

   logic [7:0]  dout;
   logic        bufoe_b;
   logic        romdis;
   logic        ready;
   logic [7:0]  rom_sel;

   modport slave (
      input  cpu_a, cpu_d, mreq_b, iorq_b, rd_b, wr_b, m1_b, romen_b,
      input  slot_mask, low_rom_en, mem_ack, mem_data,
      output mem_req, mem_addr, dout, bufoe_b, romdis, ready, rom_sel
   );

   modport master (
      output cpu_a, cpu_d, mreq_b, iorq_b, rd_b, wr_b, m1_b, romen_b,
      output slot_mask, low_rom_en, mem_ack, mem_data,
      input  mem_req, mem_addr, dout, bufoe_b, romdis, ready, rom_sel
   );
endinterface

// File: rtl/rom_bus_sequencer.sv
// Serves CPC upper/lower ROM reads from an external ROM store and tracks the upper-ROM select.
// Define ROMSEQ_WAITSTATE_EN to hold the Z80 in wait states while a fetch is outstanding.
module rom_bus_sequencer #(
   parameter int ACK_TIMEOUT = 15
) (
   input logic           clk,
   input logic           reset,
   rom_bus_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      REQ   = 2'b01,
      DRIVE = 2'b10,
      ABORT = 2'b11
   } state_t;

   localparam logic [4:0] TO_LAST = 5'(ACK_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [5:0]  sync1_q, sync2_q;
   logic        io_cond_q, rd_cond_q;
   logic [4:0]  cnt_q;
   logic [18:0] mem_addr_q;
   logic [7:0]  dout_q;
   logic [7:0]  rom_sel_q;

   logic mreq_s, iorq_s, rd_s, wr_s, m1_s, romen_s;
   logic io_cond, rd_cond, io_wr, rd_start;
   logic upper, lower, read_ok, bus_release;

   // Synchronizers idle at the inactive (high) strobe level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         // NOTE: non-blocking assignments let sync1_q and sync2_q form two real flops;
         // blocking here would collapse the chain into a single stage.
         sync1_q <= {bus.mreq_b, bus.iorq_b, bus.rd_b, bus.wr_b, bus.m1_b, bus.romen_b};
         sync2_q <= sync1_q;
      end
   end

   assign {mreq_s, iorq_s, rd_s, wr_s, m1_s, romen_s} = sync2_q;

   assign io_cond     = ~iorq_s & ~wr_s & m1_s;
   assign rd_cond     = ~mreq_s & ~rd_s & ~romen_s;
   assign io_wr       = io_cond & ~io_cond_q & ~bus.cpu_a[13];
   assign rd_start    = rd_cond & ~rd_cond_q;
   assign upper       = (bus.cpu_a[15:14] == 2'b11);
   assign lower       = ~bus.cpu_a[15];
   assign bus_release = rd_s | romen_s;
   assign read_ok     = rd_start &
                        ((upper & (rom_sel_q[7:4] == 4'h0) & bus.slot_mask[rom_sel_q[3:0]]) |
                         (lower & bus.low_rom_en));

   // Edge history resets as "already active" so a strobe held across reset release
   // must go inactive before it can start a new cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         io_cond_q <= 1'b1;
         rd_cond_q <= 1'b1;
      end else begin
         io_cond_q <= io_cond;
         rd_cond_q <= rd_cond;
      end
   end

   always_comb begin
      // NOTE: next state defaults to the current one so every path assigns it and no latch forms.
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (read_ok) state_d = REQ;
         REQ: begin
            if (rd_s)                  state_d = IDLE;
            else if (bus.mem_ack)      state_d = DRIVE;
            else if (cnt_q == TO_LAST) state_d = ABORT;
         end
         DRIVE: if (bus_release) state_d = IDLE;
         ABORT: if (bus_release) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mem_addr_q <= '0;
         dout_q     <= '0;
         rom_sel_q  <= '0;
      end else begin
         state_q <= state_d;

         if (state_q != REQ)     cnt_q <= '0;
         else if (cnt_q != 5'h1f) cnt_q <= cnt_q + 5'd1;

         // Lower-ROM fetches carry no slot number.
         if (state_q == IDLE && read_ok)
            mem_addr_q <= {lower, (lower ? 4'h0 : rom_sel_q[3:0]), bus.cpu_a[13:0]};

         if (state_q == REQ && !rd_s && bus.mem_ack)
            dout_q <= bus.mem_data;

         if (io_wr)
            rom_sel_q <= bus.cpu_d;
      end
   end

   // DRIVE is 2'b10, so the async clear to IDLE flips a single state bit and the
   // DRIVE decode behind bufoe_b cannot pulse low on the way out.
   assign bus.mem_req  = (state_q == REQ);
   assign bus.romdis   = (state_q == REQ) | ((state_q == DRIVE) & ~bus_release);
   assign bus.bufoe_b  = ~((state_q == DRIVE) & ~bus_release);
   assign bus.mem_addr = mem_addr_q;
   assign bus.dout     = dout_q;
   assign bus.rom_sel  = rom_sel_q;

`ifdef ROMSEQ_WAITSTATE_EN
   assign bus.ready = (state_q != REQ);
`else
   assign bus.ready = 1'b1;
`endif

endmodule
